// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-port responder: write-size
// encoding, MMIO register offsets, STATUS bit positions and lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_BYTE = 2'b01,
        WE_HALF = 2'b10,
        WE_WORD = 2'b11
    } we_size_t;

    // Byte offsets of the MMIO registers relative to the window base
    localparam logic [31:0] MMIO_CONSOLE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_STATUS   = 32'h0000_0004;
    localparam logic [31:0] MMIO_CYCLE_LO = 32'h0000_0008;
    localparam logic [31:0] MMIO_CYCLE_HI = 32'h0000_000C;
    localparam logic [31:0] MMIO_GPIO     = 32'h0000_0010;

    // STATUS register bit positions
    localparam int STATUS_ERR_BIT = 0;
    localparam int STATUS_OVF_BIT = 1;

    // Byte-lane enables for a write of the given size at address bits [1:0].
    // Inside the MMIO window a half write only touches lane 0.
    function automatic logic [3:0] lane_enables(input we_size_t sz,
                                                input logic [1:0] lo,
                                                input logic mmio);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            WE_BYTE: be = 4'b0001 << lo;
            WE_HALF: be = mmio ? 4'b0001 : (lo[1] ? 4'b1100 : 4'b0011);
            WE_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replace the enabled byte lanes of old_w with those of new_w
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count, async active-low reset.
// A push while full succeeds only when a pop happens in the same cycle;
// a pop while empty is ignored. dout reads 0 whenever the FIFO is empty.
module sync_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM with byte-lane writes plus an MMIO window
// (console FIFO, STATUS, 64-bit cycle counter, GPIO). Read data is the
// word at the previous cycle's address, write-first on a same-cycle write.
// Optional macro DMEM_CYCLE_CNT_EN adds the cycle counter and hi snapshot;
// without it CYCLE_LO/CYCLE_HI read 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] gpio_out,
    output logic        err
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rd_data;
    logic [31:0] r_gpio;
    logic        r_err;
    logic        r_overflow;

    we_size_t    w_sz;
    logic        w_is_mmio;
    logic [AW-1:0] w_word_idx;
    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_wr_ok;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_ram_we;
    logic [31:0] w_ram_old;
    logic [31:0] w_ram_new;
    logic [31:0] w_mmio_word;
    logic        w_sel_console;
    logic        w_sel_status;
    logic        w_sel_lo;
    logic        w_sel_hi;
    logic        w_sel_gpio;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic        w_ovf_clear;
    logic        w_err_set;
    logic [31:0] w_gpio_next;
    logic [31:0] w_rd_next;

`ifdef DMEM_CYCLE_CNT_EN
    logic [63:0] r_cycle;
    logic [31:0] r_hi_snap;
`endif

    // Address decode and write qualification
    assign w_sz           = we_size_t'(d_we);
    assign w_is_mmio      = d_addr[31];
    assign w_word_idx     = d_addr[AW+1:2];
    assign w_out_of_range = !w_is_mmio && ({3'b000, d_addr[30:2]} >= MEM_WORDS);
    assign w_misaligned   = ((w_sz == WE_HALF) && d_addr[0]) ||
                            ((w_sz == WE_WORD) && (d_addr[1:0] != 2'b00));
    assign w_wr_ok        = (w_sz != WE_NONE) && !w_misaligned;
    assign w_be           = lane_enables(w_sz, d_addr[1:0], w_is_mmio);
    assign w_err_set      = ((w_sz != WE_NONE) && w_misaligned) || w_out_of_range;

    // Right-aligned write data replicated so every lane sees its byte
    always_comb begin
        w_wdata = d_wr_data;
        case (w_sz)
            WE_BYTE: w_wdata = {4{d_wr_data[7:0]}};
            WE_HALF: w_wdata = {2{d_wr_data[15:0]}};
            default: w_wdata = d_wr_data;
        endcase
    end

    // RAM write path with lane merge
    assign w_ram_we  = w_wr_ok && !w_is_mmio && !w_out_of_range;
    assign w_ram_old = r_mem[w_word_idx];
    assign w_ram_new = merge_lanes(w_ram_old, w_wdata, w_be);

    // MMIO register selects, word-granular within the window
    assign w_mmio_word   = (d_addr - MMIO_BASE) & 32'hFFFF_FFFC;
    assign w_sel_console = w_is_mmio && (w_mmio_word == MMIO_CONSOLE);
    assign w_sel_status  = w_is_mmio && (w_mmio_word == MMIO_STATUS);
    assign w_sel_lo      = w_is_mmio && (w_mmio_word == MMIO_CYCLE_LO);
    assign w_sel_hi      = w_is_mmio && (w_mmio_word == MMIO_CYCLE_HI);
    assign w_sel_gpio    = w_is_mmio && (w_mmio_word == MMIO_GPIO);

    assign w_push      = w_wr_ok && w_sel_console;
    assign w_pop       = tx_valid && tx_ready;
    assign w_ovf_clear = w_wr_ok && w_sel_status && w_be[0] && w_wdata[STATUS_OVF_BIT];
    assign w_gpio_next = (w_wr_ok && w_sel_gpio) ? merge_lanes(r_gpio, w_wdata, w_be) : r_gpio;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (d_wr_data[7:0]),
        .dout  (tx_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign tx_valid = !w_fifo_empty;

    // Read-data selection for the word addressed this cycle (write-first)
    always_comb begin
        w_rd_next = '0;
        if (w_is_mmio) begin
            if (w_sel_console) begin
                w_rd_next = {16'b0, 8'(w_fifo_count), 6'b0, w_fifo_full, w_fifo_empty};
            end else if (w_sel_status) begin
                w_rd_next = '0;
                w_rd_next[STATUS_OVF_BIT] = r_overflow;
                w_rd_next[STATUS_ERR_BIT] = r_err;
            end else if (w_sel_lo) begin
`ifdef DMEM_CYCLE_CNT_EN
                w_rd_next = r_cycle[31:0];
`else
                w_rd_next = '0;
`endif
            end else if (w_sel_hi) begin
`ifdef DMEM_CYCLE_CNT_EN
                w_rd_next = r_hi_snap;
`else
                w_rd_next = '0;
`endif
            end else if (w_sel_gpio) begin
                w_rd_next = w_gpio_next;
            end
        end else if (!w_out_of_range) begin
            w_rd_next = w_ram_we ? w_ram_new : w_ram_old;
        end
    end

    // RAM array, contents are not reset
    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[w_word_idx] <= w_ram_new;
    end

    // Read data, GPIO and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_gpio     <= '0;
            r_err      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_data <= w_rd_next;
            r_gpio    <= w_gpio_next;
            if (w_err_set) r_err <= 1'b1;
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    // Free-running cycle counter; reading LO snapshots the upper half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle   <= '0;
            r_hi_snap <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_sel_lo) r_hi_snap <= r_cycle[63:32];
        end
    end
`endif

    assign d_rd_data = r_rd_data;
    assign gpio_out  = r_gpio;
    assign err       = r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder for the core's data port: decodes `d_addr`/`d_we`/`d_wr_data` and returns `d_rd_data`.
- Contains a word-organised data RAM with byte-lane writes.
- Contains an MMIO window with a console-transmit FIFO, a 64-bit cycle counter and a GPIO output register.
- Sits beside the core at SoC top level; the console FIFO drains to an external byte sink via valid/ready.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 8, console FIFO entries (power of 2, ≥2).
- MMIO_BASE, 32'h8000_0000, base of the MMIO window; `d_addr[31]=1` selects MMIO.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- d_addr  in  32  byte address from core
- d_we  in  2  write size: 00 none, 01 byte, 10 half, 11 word
- d_wr_data  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
- d_rd_data  out  32  aligned word at registered address, 1-cycle latency
- tx_valid  out  1  console FIFO non-empty
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  sink accepts; pop when tx_valid&&tx_ready
- gpio_out  out  32  GPIO register
- err  out  1  sticky misaligned/out-of-range flag

Behaviour:
- Reset (rst=0, async): d_rd_data=0, tx_valid=0, tx_data=0, gpio_out=0, err=0, FIFO empty, cycle counter=0, overflow=0, RAM contents undefined.
- Read: every cycle, `d_addr[31:2]` is registered; `d_rd_data` presents that full word next cycle. There is no read enable. Byte/half extraction belongs to the core LSU.
- Write-first: a write at cycle N, followed by a read of the same word with its data visible at N+1, returns the post-write word, including merged lanes.
- Byte write: lane `d_addr[1:0]`, from `d_wr_data[7:0]`.
- Half write: lanes {1,0} or {3,2} chosen by `d_addr[1]`, from `d_wr_data[15:0]`.
- Word write: all lanes.
- Misalignment: a half with addr[0]=1, or a word with addr[1:0]≠0, is dropped; err←1.
- RAM range: address beyond MEM_WORDS with `d_addr[31]=0` → write dropped, read returns 0, err←1. err clears only on reset.
- MMIO map (offset from MMIO_BASE; word/byte writes accepted, half writes treated as word-lane-0):
  - 0x00 CONSOLE:
    - Write pushes `d_wr_data[7:0]`.
    - If full, the push is dropped and overflow←1.
    - Read returns {16'b0, count[7:0], 6'b0, full, empty}.
  - 0x04 STATUS: read {30'b0, overflow, err}; writing 1 to bit1 clears overflow.
  - 0x08 CYCLE_LO:
    - Read returns counter[31:0] and latches counter[63:32] into hi_snap the same cycle.
  - 0x0C CYCLE_HI: read returns hi_snap, giving a coherent 64-bit read when LO is read first. Writes ignored.
  - 0x10 GPIO: read/write, byte-lane merge as RAM.
  - Other offsets: read 0, writes ignored, err unaffected.
- Cycle counter: +1 every cycle, wraps 2^64−1→0.
- FIFO:
  - Simultaneous push and pop when full: both succeed; count unchanged; no overflow.
  - Simultaneous push and pop when empty: push only; tx_valid rises next cycle.
  - Head byte is stable while tx_valid && !tx_ready.
- Reset mid-transfer: FIFO flushed, tx_valid drops asynchronously.

Optional Feature:
- Macro DMEM_CYCLE_CNT_EN.
- Defined: the 64-bit counter and hi_snap are present as above.
- Undefined: no counter flops; CYCLE_LO/CYCLE_HI read 0; all other behaviour unchanged.

Decomposition:
- Package dmem_pkg:
  - we_size_t enum (WE_NONE, WE_BYTE, WE_HALF, WE_WORD).
  - MMIO offset constants (MMIO_CONSOLE, MMIO_STATUS, MMIO_CYCLE_LO, MMIO_CYCLE_HI, MMIO_GPIO).
  - STATUS bit indices.
- Sub-module sync_fifo:
  - Parameterised width/depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-low reset.

Test Plan:
- Word write 0xDEADBEEF @0x10, then byte write 0x55 @0x11 → read @0x10 returns 0xDEAD55EF one cycle after address.
- Half write 0x1234 @0x22 over word 0 @0x20 → read 0x12340000; half write @0x21 → dropped, err=1, word unchanged.
- With tx_ready=0, write 9 bytes 0x41..0x49 to 0x8000_0000 → CONSOLE read count=8, full=1; STATUS=0b10 (overflow set, err clear); write 0x2 to STATUS → overflow=0. Then tx_ready=1 → tx_data 0x41..0x48 in order, one per cycle, then tx_valid=0.
- FIFO full, push 0x5A and pop the same cycle → count stays 8, overflow stays 0, 0x5A appears last.
- Preload counter near 0x0000_0000_FFFF_FFFE; read LO then HI across the carry → HI equals value at LO sample (0), not post-carry 1. Without DMEM_CYCLE_CNT_EN both read 0.
- Assert rst=0 mid-drain with 3 bytes queued → tx_valid=0 immediately; gpio_out=0, err=0 after release.
